// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe board types and constants.
// Bit 8 is square [0], bit 0 is square [8].
package ttt_pkg;

  localparam int BOARD_W = 9;

  typedef logic [BOARD_W-1:0] board_t;

  localparam int SQ0    = 8;
  localparam int SQ1    = 7;
  localparam int SQ2    = 6;
  localparam int SQ3    = 5;
  localparam int SQ4    = 4;
  localparam int SQ5    = 3;
  localparam int SQ6    = 2;
  localparam int SQ7    = 1;
  localparam int SQ8    = 0;
  localparam int CENTRE = SQ4;

  localparam board_t D1_MASK =
    board_t'((1 << SQ0) | (1 << SQ8));
  localparam board_t D2_MASK =
    board_t'((1 << SQ2) | (1 << SQ6));

  localparam board_t ADJ_MASK = 9'b010101010;

endpackage

// File: rtl/diag_owner.sv
// Flags a board that holds both ends
// of at least one diagonal.
module diag_owner
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic       owns
);

  board_t d1;
  board_t d2;

  assign d1   = board & D1_MASK;
  assign d2   = board & D2_MASK;
  assign owns = (d1 == D1_MASK) |
                (d2 == D2_MASK);

endmodule

// File: rtl/play_adjacent_edge.sv
// Opposite-corners vs centre detector;
// registers the adjacent-edge mask.
module play_adjacent_edge
  import ttt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] ain,
  input  logic [8:0] bin,
  output logic [8:0] out,
  output logic       hit,
  output logic       err
);

  logic   corners_a;
  logic   corners_b;
  logic   match;
  logic   illegal;
  board_t out_d;
  logic   hit_d;
  logic   err_d;

  diag_owner u_diag_a (
    .board (ain),
    .owns  (corners_a)
  );

  diag_owner u_diag_b (
    .board (bin),
    .owns  (corners_b)
  );

  assign match   = (corners_a & bin[CENTRE]) |
                   (corners_b & ain[CENTRE]);
  assign illegal = |(ain & bin);

  // Next outputs: illegal board overrides any match.
  always_comb begin
    out_d = '0;
    hit_d = 1'b0;
    err_d = 1'b0;
    if (illegal) begin
      err_d = 1'b1;
    end else if (match) begin
      hit_d = 1'b1;
      out_d = ADJ_MASK;
    end
  end

  // One-cycle output register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      hit <= 1'b0;
      err <= 1'b0;
    end else begin
      out <= out_d;
      hit <= hit_d;
      err <= err_d;
    end
  end

endmodule

// File: tb/tb_play_adjacent_edge.sv
// Randomised + directed bench for
// play_adjacent_edge against a board model.
module tb_play_adjacent_edge;

  logic       clk;
  logic       rst_n;
  logic [8:0] ain;
  logic [8:0] bin;
  logic [8:0] out;
  logic       hit;
  logic       err;

  int n_chk;
  int n_fail;

  play_adjacent_edge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ain   (ain),
    .bin   (bin),
    .out   (out),
    .hit   (hit),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Square s (0..8, row-major) of a board.
  function automatic bit sq(
    input logic [8:0] b, input int s
  );
    return b[8-s];
  endfunction

  // Player owns both corners of some diagonal.
  function automatic bit owns_diag(
    input logic [8:0] b
  );
    int diag [2][2] = '{'{0, 8}, '{2, 6}};
    for (int d = 0; d < 2; d++)
      if (sq(b, diag[d][0]) && sq(b, diag[d][1]))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] e_out,
    output logic       e_hit,
    output logic       e_err
  );
    bit clash;
    bit m;
    clash = 1'b0;
    for (int s = 0; s < 9; s++)
      if (sq(a, s) && sq(b, s)) clash = 1'b1;
    m = (owns_diag(a) && sq(b, 4)) ||
        (owns_diag(b) && sq(a, 4));
    e_err = clash;
    e_hit = !clash && m;
    e_out = e_hit ? 9'b010101010 : 9'd0;
  endtask

  task automatic apply(
    input string      tag,
    input logic [8:0] a,
    input logic [8:0] b
  );
    logic [8:0] e_out;
    logic       e_hit;
    logic       e_err;
    @(negedge clk);
    ain = a;
    bin = b;
    @(posedge clk);
    #1;
    model(a, b, e_out, e_hit, e_err);
    check({tag, ".out"}, 32'(out), 32'(e_out));
    check({tag, ".hit"}, 32'(hit), 32'(e_hit));
    check({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"}, 32'(out), 32'd0);
    check({tag, ".hit"}, 32'(hit), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [8:0] a;
    logic [8:0] b;
    int         r;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    ain    = 9'b100000001;
    bin    = 9'b000010000;
    #1 rst_n = 1'b0;
    #2;
    check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    apply("d1_a",   9'b100000001, 9'b000010000);
    check("d1_a.abs", 32'(out), 32'h0AA);
    apply("d2_a",   9'b001000100, 9'b000010000);
    apply("d1_b",   9'b000010000, 9'b100000001);
    apply("d2_b",   9'b000010000, 9'b001000100);
    apply("none",   9'b110001000, 9'b001100010);
    apply("empty",  9'b000000000, 9'b000000000);
    apply("both_d", 9'b101000101, 9'b000010000);
    apply("full",   9'b101010100, 9'b010101011);

    // Input change between edges must not show.
    apply("hold",   9'b100000001, 9'b000010000);
    #2;
    ain = 9'b000000000;
    bin = 9'b000000000;
    #1;
    check("hold.mid", 32'(out), 32'h0AA);

    apply("ovl",    9'b100010001, 9'b000010000);
    check("ovl.abs", 32'(err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      a = '0;
      b = '0;
      for (int s = 0; s < 9; s++) begin
        r = $urandom_range(0, 9);
        if (r >= 7)      b[8-s] = 1'b1;
        else if (r >= 4) a[8-s] = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          a |= 9'b100000001;
          b &= ~9'b100000001;
        end else begin
          a |= 9'b001000100;
          b &= ~9'b001000100;
        end
        a[4] = 1'b0;
        b[4] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          {a, b} = {b, a};
        end
      end
      if ($urandom_range(0, 9) == 0)
        b[$urandom_range(0, 8)] = 1'b1;
      if ($urandom_range(0, 9) == 0)
        a[$urandom_range(0, 8)] = 1'b1;
      apply("rand", a, b);
    end

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
